// File: rtl/aux_pkg.sv
// Shared types for the AUX request arbiter: FSM states, 2-bit AUX command codes,
// the latched transaction record, the default WAIT timeout and the round-robin pick.
package aux_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } aux_state_e;

   typedef enum logic [1:0] {
      AUX_CMD_WRITE        = 2'b00,
      AUX_CMD_READ         = 2'b01,
      AUX_CMD_WRITE_STATUS = 2'b10,
      AUX_CMD_RSVD         = 2'b11
   } aux_cmd_e;

   localparam int AUX_TIMEOUT_CYCLES_DEFAULT = 400;

   typedef struct packed {
      aux_cmd_e    cmd;
      logic [19:0] addr;
      logic [7:0]  len;
      logic [7:0]  data;
   } aux_msg_t;

   // On contention the side that was not served last wins; nat_next=1 favours native.
   function automatic logic rr_pick_i2c(input logic nat, input logic i2c, input logic nat_next);
      return i2c & (~nat | ~nat_next);
   endfunction

endpackage

// File: rtl/aux_timeout_ctr.sv
// WAIT-phase watchdog: counts enabled cycles from a clear, expire is combinational on the
// LIMIT-th enabled cycle; no backpressure, it only observes the arbiter state.
module aux_timeout_ctr #(
   parameter int LIMIT = 400
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] r_cnt;

   assign o_expire = i_en && (r_cnt == CW'(LIMIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_expire) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/aux_req_arbiter.sv
// Round-robin arbiter between native and I2C-over-AUX requesters; grant and start one cycle
// after a request is seen in IDLE; requesters hold req until granted. AUX_ARB_TIMEOUT_EN adds a WAIT timeout.
module aux_req_arbiter
   import aux_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = AUX_TIMEOUT_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        nat_req,
   input  logic [1:0]  nat_cmd,
   input  logic [19:0] nat_addr,
   input  logic [7:0]  nat_len,
   input  logic [7:0]  nat_data,
   input  logic        i2c_req,
   input  logic [1:0]  i2c_cmd,
   input  logic [19:0] i2c_addr,
   input  logic [7:0]  i2c_len,
   output logic        nat_gnt,
   output logic        i2c_gnt,
   input  logic        aux_tr_done,
   input  logic        aux_tr_ack,
   output logic [1:0]  ctrl_msg_cmd,
   output logic [7:0]  ctrl_msg_data,
   output logic [19:0] ctrl_msg_address,
   output logic [7:0]  ctrl_msg_len,
   output logic        ctrl_tr_vld,
   output logic        ctrl_i2c_native,
   output logic        nat_done,
   output logic        i2c_done,
   output logic        tr_ack,
   output logic        timeout_err
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("aux_req_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   aux_state_e r_state;
   aux_msg_t   r_msg;
   logic       r_nat_next;
   logic       r_nat_gnt;
   logic       r_i2c_gnt;
   logic       r_tr_vld;
   logic       r_i2c_native;
   logic       r_nat_done;
   logic       r_i2c_done;
   logic       r_tr_ack;

   logic       w_any_req;
   logic       w_pick_i2c;
   aux_msg_t   w_nat_msg;
   aux_msg_t   w_i2c_msg;

   assign w_any_req  = nat_req | i2c_req;
   assign w_pick_i2c = rr_pick_i2c(nat_req, i2c_req, r_nat_next);

   // The I2C path carries no inline data byte, so its record is zero-filled there.
   always_comb begin
      w_nat_msg      = '0;
      w_nat_msg.cmd  = aux_cmd_e'(nat_cmd);
      w_nat_msg.addr = nat_addr;
      w_nat_msg.len  = nat_len;
      w_nat_msg.data = nat_data;
      w_i2c_msg      = '0;
      w_i2c_msg.cmd  = aux_cmd_e'(i2c_cmd);
      w_i2c_msg.addr = i2c_addr;
      w_i2c_msg.len  = i2c_len;
      w_i2c_msg.data = 8'h00;
   end

`ifdef AUX_ARB_TIMEOUT_EN
   logic w_expire;
   logic r_timeout_err;

   aux_timeout_ctr #(
      .LIMIT    (TIMEOUT_CYCLES)
   ) u_timeout_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clr    (r_state == ISSUE),
      .i_en     (r_state == WAIT),
      .o_expire (w_expire)
   );

   assign timeout_err = r_timeout_err;
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_msg         <= '0;
         r_nat_next    <= 1'b1;
         r_nat_gnt     <= 1'b0;
         r_i2c_gnt     <= 1'b0;
         r_tr_vld      <= 1'b0;
         r_i2c_native  <= 1'b0;
         r_nat_done    <= 1'b0;
         r_i2c_done    <= 1'b0;
         r_tr_ack      <= 1'b0;
`ifdef AUX_ARB_TIMEOUT_EN
         r_timeout_err <= 1'b0;
`endif
      end else begin
         r_nat_gnt     <= 1'b0;
         r_i2c_gnt     <= 1'b0;
         r_tr_vld      <= 1'b0;
         r_nat_done    <= 1'b0;
         r_i2c_done    <= 1'b0;
`ifdef AUX_ARB_TIMEOUT_EN
         r_timeout_err <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_state      <= ISSUE;
                  r_tr_vld     <= 1'b1;
                  r_nat_gnt    <= ~w_pick_i2c;
                  r_i2c_gnt    <= w_pick_i2c;
                  r_i2c_native <= w_pick_i2c;
                  r_nat_next   <= w_pick_i2c;
                  r_msg        <= w_pick_i2c ? w_i2c_msg : w_nat_msg;
               end
            end
            ISSUE: begin
               r_state <= WAIT;
            end
            WAIT: begin
               if (aux_tr_done) begin
                  r_state    <= DONE;
                  r_tr_ack   <= aux_tr_ack;
                  r_nat_done <= ~r_i2c_native;
                  r_i2c_done <= r_i2c_native;
               end
`ifdef AUX_ARB_TIMEOUT_EN
               else if (w_expire) begin
                  r_state       <= DONE;
                  r_tr_ack      <= 1'b0;
                  r_timeout_err <= 1'b1;
                  r_nat_done    <= ~r_i2c_native;
                  r_i2c_done    <= r_i2c_native;
               end
`endif
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign nat_gnt          = r_nat_gnt;
   assign i2c_gnt          = r_i2c_gnt;
   assign ctrl_tr_vld      = r_tr_vld;
   assign ctrl_i2c_native  = r_i2c_native;
   assign ctrl_msg_cmd     = r_msg.cmd;
   assign ctrl_msg_address = r_msg.addr;
   assign ctrl_msg_len     = r_msg.len;
   assign ctrl_msg_data    = r_msg.data;
   assign nat_done         = r_nat_done;
   assign i2c_done         = r_i2c_done;
   assign tr_ack           = r_tr_ack;

endmodule

// File: doc/aux_req_arbiter.md
AUX_REQ_ARBITER -- requirements
Module: aux_req_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 400, meaning clk cycles allowed in WAIT before timeout.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports nat_req / nat_cmd / nat_addr / nat_len / nat_data  in  1/2/20/8/8  native AUX requester, held until granted.
REQ-005 SHALL have ports i2c_req / i2c_cmd / i2c_addr / i2c_len  in  1/2/20/8  I2C-over-AUX requester, held until granted.
REQ-006 SHALL have ports nat_gnt and i2c_gnt  out  1 each  one-cycle grant pulses.
REQ-007 SHALL have ports aux_tr_done and aux_tr_ack  in  1 each  transaction-complete pulse, reply ACK (1) / NACK (0) qualifier.
REQ-008 SHALL have ports ctrl_msg_cmd / ctrl_msg_data / ctrl_msg_address / ctrl_msg_len  out  2/8/20/8  registered transaction fields.
REQ-009 SHALL have ports ctrl_tr_vld and ctrl_i2c_native  out  1 each  start pulse; path select (1 = I2C, 0 = native).
REQ-010 SHALL have ports nat_done / i2c_done / tr_ack / timeout_err  out  1 each  completion pulse to owner, ACK status, timeout flag.

Function
REQ-011 SHALL use FSM states IDLE, ISSUE, WAIT, DONE.
REQ-012 In IDLE with any req high, SHALL move to ISSUE next cycle and pulse the selected grant in that ISSUE cycle.
REQ-013 On a simultaneous nat_req and i2c_req, SHALL grant round-robin: the requester not served last wins; after reset, native wins.
REQ-014 SHALL latch the winner's fields into ctrl_msg_* on the IDLE->ISSUE edge; ctrl_msg_data SHALL be 0 for I2C grants.
REQ-015 SHALL hold ctrl_msg_* and ctrl_i2c_native stable from ISSUE until the return to IDLE.
REQ-016 SHALL pulse ctrl_tr_vld for exactly the one ISSUE cycle; ISSUE->WAIT is unconditional.
REQ-017 In WAIT, aux_tr_done SHALL move the FSM to DONE and register tr_ack = aux_tr_ack.
REQ-018 In DONE, SHALL pulse nat_done or i2c_done (owner only) for one cycle, then return to IDLE.
REQ-019 Minimum request-to-request cycle SHALL be 4 cycles plus WAIT duration.
REQ-020 aux_tr_done seen outside WAIT SHALL be ignored.
REQ-021 A requester dropping req before grant SHALL lose arbitration without side effects.
REQ-022 ctrl_i2c_native SHALL keep its last value in IDLE.

Reset
REQ-023 rst_n low SHALL asynchronously force state IDLE, all outputs 0, and the round-robin pointer to "native next", aborting any transaction in flight with no done pulse.

Configuration
REQ-024 With AUX_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT; at TIMEOUT_CYCLES without aux_tr_done, the FSM SHALL go to DONE with tr_ack=0 and timeout_err=1 for that done pulse.
REQ-025 With AUX_ARB_TIMEOUT_EN undefined, WAIT SHALL persist until aux_tr_done, timeout_err SHALL be tied to 0, and no counter logic SHALL exist.

Structure
REQ-026 Package aux_pkg SHALL hold the state enum, the AUX command encodings (2-bit), and the default TIMEOUT_CYCLES constant.
REQ-027 The timeout counter SHALL be sub-module aux_timeout_ctr (clear, enable, expire), instantiated only under AUX_ARB_TIMEOUT_EN.

Verification
REQ-028 Single native request: nat_req, addr 0x00100, len 1, data 0xA5 -> nat_gnt plus ctrl_tr_vld one cycle later, ctrl_i2c_native=0; aux_tr_done with ack=1 -> nat_done, tr_ack=1.
REQ-029 Simultaneous requests twice -> first grant native, second I2C; I2C grant drives ctrl_i2c_native=1 and ctrl_msg_data=0.
REQ-030 Timeout with AUX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no aux_tr_done -> DONE after 8 WAIT cycles, timeout_err=1, tr_ack=0.
REQ-031 NACK: aux_tr_done with aux_tr_ack=0 -> owner done pulse, tr_ack=0, timeout_err=0.
REQ-032 Reset mid-WAIT: rst_n low -> immediate IDLE, outputs 0, no done pulse; next simultaneous request goes to native.
REQ-033 Stray aux_tr_done in IDLE -> no state change, no done pulse.
